sha256_pad_ctrl: RTL and testbench

Sequencer in front of the SHA-256 compression core (sha_transform).
- Accepts a message as a byte stream.
- Assembles 512-bit blocks in big-endian order and applies FIPS 180-4 padding: 0x80, zero fill, 64-bit big-endian bit length.
- Issues one load per block and waits for the core's done before building the next block.
- Owns all block, length and first/final-block bookkeeping, so the core only sees complete 16-word blocks.

---
 rtl/sha256_pkg.sv | 9 +
 rtl/sha256_blk_buf.sv | 35 +++
 rtl/sha256_pad_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sha256_pad_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 padding sequencer and its block buffer.
package sha256_pkg;
  localparam int BLOCK_BYTES = 64;
  localparam int LEN_OFFSET  = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef logic [7:0] byte_t;
  typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, WAIT} state_t;
endpackage

// File: rtl/sha256_blk_buf.sv
// 64-byte block register: single byte write, 8-byte big-endian length insert at byte 56,
// synchronous clear; byte 0 appears at blk_data[511:504].
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [5:0]   wr_idx,
  input  byte_t        wr_dat,
  input  logic         len_en,
  input  logic [63:0]  len_val,
  output logic [511:0] blk_data
);
  byte_t mem [BLOCK_BYTES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BLOCK_BYTES; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < BLOCK_BYTES; i++) mem[i] <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_dat;
      if (len_en) begin
        for (int i = 0; i < 8; i++) mem[LEN_OFFSET + i] <= len_val[63 - 8*i -: 8];
      end
    end
  end

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) blk_data[511 - 8*i -: 8] = mem[i];
  end
endmodule

// File: rtl/sha256_pad_ctrl.sv
// SHA-256 front end: byte stream in, FIPS 180-4 padded 512-bit blocks out, in_ready low from issue to blk_done.
// Define SHA256_PAD_BLK_CNT_EN to add the saturating per-message blk_cnt output.
module sha256_pad_ctrl #(
  parameter int LEN_W       = 64,
  parameter int BLOCK_BYTES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  input  logic         in_keep,
  output logic [511:0] blk_data,
  output logic         blk_load,
  output logic         blk_first,
  output logic         blk_final,
  input  logic         blk_done,
  output logic         msg_done
`ifdef SHA256_PAD_BLK_CNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);
  import sha256_pkg::*;

  localparam logic [6:0] FULL   = 7'(BLOCK_BYTES);
  localparam logic [6:0] LEN_AT = 7'(LEN_OFFSET);

  state_t           state;
  logic [6:0]       byte_idx;
  logic [LEN_W-1:0] bit_len;
  logic             first_pend, final_pend, pad_pend, len_pend;

  logic        accept, buf_clr, buf_wr, len_en;
  logic [6:0]  idx_inc;
  byte_t       wr_dat;
  logic [63:0] len64;

  assign accept  = in_valid && in_ready;
  assign idx_inc = byte_idx + 7'd1;
  assign buf_clr = (state == WAIT) && blk_done;
  assign buf_wr  = (accept && in_keep) || ((state == PAD) && (byte_idx != FULL));
  assign wr_dat  = (state == PAD) ? PAD_BYTE : in_data;
  assign len_en  = (state == LEN);

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = bit_len;
  end

  sha256_blk_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr      (buf_clr),
    .wr_en    (buf_wr),
    .wr_idx   (byte_idx[5:0]),
    .wr_dat   (wr_dat),
    .len_en   (len_en),
    .len_val  (len64),
    .blk_data (blk_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_idx   <= '0;
      bit_len    <= '0;
      first_pend <= 1'b0;
      final_pend <= 1'b0;
      pad_pend   <= 1'b0;
      len_pend   <= 1'b0;
      in_ready   <= 1'b0;
      blk_load   <= 1'b0;
      blk_first  <= 1'b0;
      blk_final  <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      blk_load  <= 1'b0;
      blk_first <= 1'b0;
      blk_final <= 1'b0;
      msg_done  <= 1'b0;
      case (state)
        IDLE, FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (in_keep) begin
              byte_idx <= idx_inc;
              bit_len  <= bit_len + LEN_W'(8);
            end
            if (state == IDLE) first_pend <= 1'b1;
            // in_last wins over a full block so the pad step can decide on the extra block
            if (in_last) begin
              state    <= PAD;
              in_ready <= 1'b0;
            end else if (in_keep && (idx_inc == FULL)) begin
              state     <= ISSUE;
              in_ready  <= 1'b0;
              blk_load  <= 1'b1;
              blk_first <= first_pend;
            end else begin
              state <= FILL;
            end
          end
        end
        PAD: begin
          if (byte_idx == FULL) begin
            pad_pend  <= 1'b1;
            state     <= ISSUE;
            blk_load  <= 1'b1;
            blk_first <= first_pend;
          end else begin
            byte_idx <= idx_inc;
            if (idx_inc <= LEN_AT) begin
              state <= LEN;
            end else begin
              len_pend  <= 1'b1;
              state     <= ISSUE;
              blk_load  <= 1'b1;
              blk_first <= first_pend;
            end
          end
        end
        LEN: begin
          final_pend <= 1'b1;
          state      <= ISSUE;
          blk_load   <= 1'b1;
          blk_first  <= first_pend;
          blk_final  <= 1'b1;
        end
        ISSUE: begin
          first_pend <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (blk_done) begin
            byte_idx <= '0;
            if (final_pend) begin
              msg_done   <= 1'b1;
              bit_len    <= '0;
              first_pend <= 1'b0;
              final_pend <= 1'b0;
              pad_pend   <= 1'b0;
              len_pend   <= 1'b0;
              in_ready   <= 1'b1;
              state      <= IDLE;
            end else if (pad_pend) begin
              pad_pend <= 1'b0;
              state    <= PAD;
            end else if (len_pend) begin
              len_pend <= 1'b0;
              state    <= LEN;
            end else begin
              in_ready <= 1'b1;
              state    <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA256_PAD_BLK_CNT_EN
  // Cleared the cycle after msg_done so the count is still visible alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (msg_done) begin
      blk_cnt <= '0;
    end else if (blk_load && (blk_cnt != 16'hFFFF)) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Bench for sha256_pad_ctrl: a reference padder fills the expected-block queue per message,
// and a simple core responder collects issued blocks for per-test comparison.
module tb_sha256_pad_ctrl;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last, in_keep;
  logic [7:0]   in_data;
  logic [511:0] blk_data;
  logic         blk_load, blk_first, blk_final, blk_done, msg_done;
`ifdef SHA256_PAD_BLK_CNT_EN
  logic [15:0]  blk_cnt;
`endif

  always #5 clk = ~clk;

  sha256_pad_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_keep   (in_keep),
    .blk_data  (blk_data),
    .blk_load  (blk_load),
    .blk_first (blk_first),
    .blk_final (blk_final),
    .blk_done  (blk_done),
    .msg_done  (msg_done)
`ifdef SHA256_PAD_BLK_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  byte_t        msg_q[$];
  logic [511:0] exp_blk[$];
  bit           exp_first[$];
  bit           exp_final[$];
  logic [511:0] got_blk[$];
  bit           got_first[$];
  bit           got_final[$];
  int           got_cyc[$];
  int           last_beat_cyc, done_cyc, msg_cyc, bp_viol, cnt_at_done;
  logic         ready_after;

  // Reference padding: append 0x80, zero to 56 mod 64, then the 64-bit bit length.
  task automatic model_push();
    byte_t       p[$];
    logic [63:0] bits;
    p = msg_q;
    bits = 64'(msg_q.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    for (int b = 0; b < p.size() / 64; b++) begin
      logic [511:0] w;
      for (int i = 0; i < 64; i++) w[511 - 8*i -: 8] = p[64*b + i];
      exp_blk.push_back(w);
      exp_first.push_back(b == 0);
      exp_final.push_back(b == p.size() / 64 - 1);
    end
  endtask

  // Streams msg_q and answers each blk_load with blk_done dly cycles later.
  task automatic run_msg(input int dly, input bit spurious, input bit abort, input int budget);
    int n, nbeats, idx, cyc, cd;
    bit cd_act, acc, fin;
    logic [511:0] hold;
    n = msg_q.size();
    nbeats = (n == 0) ? 1 : n;
    idx = 0; cyc = 0; cd = 0; cd_act = 0; acc = 0; fin = 0; hold = '0;
    got_blk.delete(); got_first.delete(); got_final.delete(); got_cyc.delete();
    last_beat_cyc = -1; done_cyc = -100; msg_cyc = -1; bp_viol = 0; cnt_at_done = -1;
    ready_after = 1'bx;
    while (!fin && cyc < budget) begin
      @(posedge clk); #1; cyc++;
      if (acc) idx++;
      if (cd_act && (in_ready !== 1'b0 || blk_data !== hold)) bp_viol++;
      if (cyc == done_cyc + 1) ready_after = in_ready;
      if (msg_done === 1'b1) begin
        msg_cyc = cyc;
        fin = 1;
`ifdef SHA256_PAD_BLK_CNT_EN
        cnt_at_done = int'(blk_cnt);
`endif
      end
      blk_done = 1'b0;
      if (cd_act) begin
        cd--;
        if (cd == 0) begin
          blk_done = 1'b1;
          cd_act = 0;
          done_cyc = cyc;
        end
      end
      if (blk_load === 1'b1) begin
        got_blk.push_back(blk_data);
        got_first.push_back(blk_first);
        got_final.push_back(blk_final);
        got_cyc.push_back(cyc);
        hold = blk_data;
        cd = dly;
        cd_act = 1;
        if (spurious) blk_done = 1'b1;
        if (abort) begin
          blk_done = 1'b0;
          fin = 1;
          break;
        end
      end
      if (idx < nbeats) begin
        in_valid = 1'b1;
        in_keep  = (n != 0);
        in_last  = (idx == nbeats - 1);
        in_data  = 8'h00;
        if (n != 0) in_data = msg_q[idx];
      end else begin
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0; in_data = 8'h00;
      end
      acc = in_valid && (in_ready === 1'b1);
      if (acc && in_last) last_beat_cyc = cyc;
    end
    in_valid = 1'b0; in_last = 1'b0; in_keep = 1'b0; blk_done = 1'b0;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL run_timeout: no completion within %0d cycles (blocks seen %0d)", budget, got_blk.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_keep = 1'b0; blk_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, blk_load, blk_first, blk_final, msg_done} !== 5'b0 || blk_data !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ctl=%b data_nonzero=%b, want all 0", {in_ready, blk_load, blk_first, blk_final, msg_done}, blk_data !== '0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_abc(input string tag);
    msg_q = '{8'h61, 8'h62, 8'h63};
    model_push();
    run_msg(2, 1'b0, 1'b0, 200);
    tests++;
    if (got_blk.size() !== 1) begin
      fails++; $display("FAIL %s_count: got %0d blocks want 1", tag, got_blk.size());
    end
    if (got_blk.size() >= 1) begin
      tests++;
      if (got_blk[0] !== {32'h61626380, 448'h0, 32'h00000018}) begin
        fails++; $display("FAIL %s_data: got %h want 61626380..00000018", tag, got_blk[0]);
      end
      tests++;
      if (got_blk[0] !== exp_blk[0] || got_first[0] !== 1'b1 || got_final[0] !== 1'b1) begin
        fails++; $display("FAIL %s_flags: first=%b final=%b want 1 1", tag, got_first[0], got_final[0]);
      end
      tests++;
      if (got_cyc[0] - last_beat_cyc !== 3) begin
        fails++; $display("FAIL %s_latency: load %0d cycles after last beat want 3", tag, got_cyc[0] - last_beat_cyc);
      end
    end
    tests++;
    if (msg_cyc !== done_cyc + 1 || ready_after !== 1'b1) begin
      fails++; $display("FAIL %s_msg_done: at %0d ready=%b want %0d ready=1", tag, msg_cyc, ready_after, done_cyc + 1);
    end
`ifdef SHA256_PAD_BLK_CNT_EN
    tests++;
    if (cnt_at_done !== 1) begin
      fails++; $display("FAIL %s_blk_cnt: got %0d want 1", tag, cnt_at_done);
    end
`endif
    exp_blk.delete(); exp_first.delete(); exp_final.delete();
  endtask

  task automatic test_empty();
    msg_q.delete();
    model_push();
    run_msg(3, 1'b0, 1'b0, 200);
    tests++;
    if (got_blk.size() !== 1 || got_blk[0] !== {32'h80000000, 480'h0} || got_blk[0] !== exp_blk[0]) begin
      fails++; $display("FAIL empty_block: got %0d blocks, first %h want 80000000 then zeros", got_blk.size(), got_blk.size() > 0 ? got_blk[0] : '0);
    end
    tests++;
    if (got_first.size() < 1 || got_first[0] !== 1'b1 || got_final[0] !== 1'b1 || msg_cyc !== done_cyc + 1) begin
      fails++; $display("FAIL empty_flags: msg_done at %0d want %0d, first/final must be 1", msg_cyc, done_cyc + 1);
    end
    exp_blk.delete(); exp_first.delete(); exp_final.delete();
  endtask

  task automatic test_56();
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'hAA);
    model_push();
    run_msg(2, 1'b0, 1'b0, 400);
    tests++;
    if (got_blk.size() !== 2) begin
      fails++; $display("FAIL b56_count: got %0d blocks want 2", got_blk.size());
    end else begin
      tests++;
      if (got_blk[0] !== {{56{8'hAA}}, 8'h80, 56'h0} || got_first[0] !== 1'b1 || got_final[0] !== 1'b0) begin
        fails++; $display("FAIL b56_blk1: got %h first=%b final=%b", got_blk[0], got_first[0], got_final[0]);
      end
      tests++;
      if (got_blk[1] !== {480'h0, 32'h000001C0} || got_blk[1] !== exp_blk[1] || got_first[1] !== 1'b0 || got_final[1] !== 1'b1) begin
        fails++; $display("FAIL b56_blk2: got %h first=%b final=%b want len 1C0 final", got_blk[1], got_first[1], got_final[1]);
      end
    end
`ifdef SHA256_PAD_BLK_CNT_EN
    tests++;
    if (cnt_at_done !== 2) begin
      fails++; $display("FAIL b56_blk_cnt: got %0d want 2", cnt_at_done);
    end
`endif
    exp_blk.delete(); exp_first.delete(); exp_final.delete();
  endtask

  task automatic test_64();
    logic [511:0] raw;
    msg_q.delete();
    for (int i = 0; i < 64; i++) begin
      msg_q.push_back(8'(i));
      raw[511 - 8*i -: 8] = 8'(i);
    end
    model_push();
    run_msg(4, 1'b0, 1'b0, 400);
    tests++;
    if (got_blk.size() !== 2) begin
      fails++; $display("FAIL b64_count: got %0d blocks want 2", got_blk.size());
    end else begin
      tests++;
      if (got_blk[0] !== raw || got_first[0] !== 1'b1 || got_final[0] !== 1'b0) begin
        fails++; $display("FAIL b64_blk1: got %h first=%b final=%b", got_blk[0], got_first[0], got_final[0]);
      end
      tests++;
      if (got_blk[1] !== {32'h80000000, 448'h0, 32'h00000200} || got_final[1] !== 1'b1 || got_first[1] !== 1'b0) begin
        fails++; $display("FAIL b64_blk2: got %h first=%b final=%b", got_blk[1], got_first[1], got_final[1]);
      end
    end
    exp_blk.delete(); exp_first.delete(); exp_final.delete();
  endtask

  task automatic test_backpressure();
    msg_q.delete();
    for (int i = 0; i < 10; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    model_push();
    // blk_done also raised in the issue cycle, where it must be ignored
    run_msg(21, 1'b1, 1'b0, 300);
    tests++;
    if (bp_viol !== 0) begin
      fails++; $display("FAIL bp_stall: %0d cycles with in_ready high or blk_data changing, want 0", bp_viol);
    end
    tests++;
    if (got_blk.size() !== 1 || got_blk[0] !== exp_blk[0] || msg_cyc - got_cyc[0] !== 22) begin
      fails++; $display("FAIL bp_block: blocks=%0d msg_done %0d cycles after load want 22", got_blk.size(), msg_cyc - (got_cyc.size() > 0 ? got_cyc[0] : 0));
    end
    tests++;
    if (ready_after !== 1'b1) begin
      fails++; $display("FAIL bp_release: in_ready=%b after blk_done want 1", ready_after);
    end
    exp_blk.delete(); exp_first.delete(); exp_final.delete();
  endtask

  task automatic test_lengths();
    int lens[8] = '{1, 55, 57, 63, 65, 119, 128, 200};
    foreach (lens[k]) begin
      msg_q.delete();
      for (int i = 0; i < lens[k]; i++) msg_q.push_back(8'($urandom_range(0, 255)));
      model_push();
      run_msg(1 + k % 3, 1'b0, 1'b0, 2000);
      tests++;
      if (got_blk.size() !== exp_blk.size()) begin
        fails++; $display("FAIL len%0d_count: got %0d blocks want %0d", lens[k], got_blk.size(), exp_blk.size());
      end
      while (got_blk.size() > 0 && exp_blk.size() > 0) begin
        logic [511:0] g, x;
        bit gf, gl, xf, xl;
        g = got_blk.pop_front(); gf = got_first.pop_front(); gl = got_final.pop_front();
        x = exp_blk.pop_front(); xf = exp_first.pop_front(); xl = exp_final.pop_front();
        tests++;
        if (g !== x || gf !== xf || gl !== xl) begin
          fails++; $display("FAIL len%0d_block: got %h f=%b l=%b want %h f=%b l=%b", lens[k], g, gf, gl, x, xf, xl);
        end
      end
      exp_blk.delete(); exp_first.delete(); exp_final.delete();
    end
  endtask

  task automatic test_reset_mid();
    msg_q.delete();
    for (int i = 0; i < 70; i++) msg_q.push_back(8'hAA);
    run_msg(5, 1'b0, 1'b1, 300);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, blk_load, blk_first, blk_final, msg_done} !== 5'b0 || blk_data !== '0 || got_blk.size() !== 1) begin
      fails++; $display("FAIL rst_mid: ctl=%b data_nonzero=%b blocks=%0d want 0 0 1", {in_ready, blk_load, blk_first, blk_final, msg_done}, blk_data !== '0, got_blk.size());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    test_abc("after_rst");
  endtask

  initial begin
    test_reset();
    test_abc("abc");
    test_empty();
    test_56();
    test_64();
    test_backpressure();
    test_lengths();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
